// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write sequencer: FSM state encoding, strobe
// phase encoding, counter width, init nibble values and the slow command codes
// (clear / return home) that need the long post-byte wait.
package lcd_pkg;

    localparam int unsigned CntWidth = 20;

    typedef enum logic [3:0] {
        StPwrWait,
        StInitNib,
        StInitWait,
        StIdle,
        StSetupHi,
        StEnHi,
        StGap,
        StSetupLo,
        StEnLo,
        StPostWait
    } state_e;

    // PhStrobe covers setup and enable in one counted window (init path).
    typedef enum logic [2:0] {
        PhOff,
        PhSetup,
        PhEnable,
        PhStrobe,
        PhHold
    } phase_e;

    localparam logic [3:0] InitNibWake = 4'h3;
    localparam logic [3:0] InitNibLast = 4'h2;

    localparam logic [7:0] CmdClear   = 8'h01;
    localparam logic [7:0] CmdHome    = 8'h02;
    localparam logic [7:0] CmdHomeAlt = 8'h03;

    // Three wake-up nibbles, then the switch to 4-bit mode.
    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        return (idx == 2'd3) ? InitNibLast : InitNibWake;
    endfunction

    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] code);
        return !rs && (code == CmdClear || code == CmdHome || code == CmdHomeAlt);
    endfunction

endpackage

// File: rtl/lcd_write_sequencer_if.sv
// Host handshake plus 4-bit LCD bus.
//   request/rs/data : byte write request from the host
//   ready/init_done : handshake ready, power-on init finished
//   lcd_*           : E, RS, StrataFlash disable, R/W, DB[7:4]
interface lcd_write_sequencer_if;
    logic       request;
    logic       rs;
    logic [7:0] data;
    logic       ready;
    logic       init_done;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_sf_ce;
    logic       lcd_rw;
    logic [3:0] lcd_data;

    modport master (
        output request, rs, data,
        input  ready, init_done, lcd_e, lcd_rs, lcd_sf_ce, lcd_rw, lcd_data
    );

    modport slave (
        input  request, rs, data,
        output ready, init_done, lcd_e, lcd_rs, lcd_sf_ce, lcd_rw, lcd_data
    );
endinterface

// File: rtl/lcd_nibble_strobe.sv
// Drives E/RS/DB for one nibble from the current strobe phase.
//   phase  : off, setup, enable, combined setup+enable (counter split), hold
//   cnt    : shared down-counter, only used in the combined phase
//   rs     : register select to present
//   nibble : data nibble to present
//   e, rs_out, data : LCD pins
module lcd_nibble_strobe
    import lcd_pkg::*;
#(
    parameter int unsigned ENABLE_CYCLES = 12
) (
    input  phase_e              phase,
    input  logic [CntWidth-1:0] cnt,
    input  logic                rs,
    input  logic [3:0]          nibble,
    output logic                e,
    output logic                rs_out,
    output logic [3:0]          data
);

    always_comb begin
        e      = 1'b0;
        rs_out = rs;
        data   = nibble;
        case (phase)
            PhOff: begin
                rs_out = 1'b0;
                data   = 4'h0;
            end
            PhEnable: e = 1'b1;
            // Counter runs down through setup first; the last ENABLE_CYCLES
            // counts are the E-high window.
            PhStrobe: e = (cnt <= CntWidth'(ENABLE_CYCLES));
            default:  e = 1'b0;
        endcase
    end

endmodule

// File: rtl/lcd_write_sequencer.sv
// Power-on init and byte write sequencer for an HD44780-style LCD in 4-bit mode.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, restarts the full power-on init
//   bus   : host handshake (request/rs/data -> ready/init_done) and LCD pins
// One down-counter times every wait; a wait of N occupies exactly N cycles.
module lcd_write_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned PWR_WAIT_CYCLES   = 750000,
    parameter int unsigned INIT1_WAIT_CYCLES = 205000,
    parameter int unsigned INIT2_WAIT_CYCLES = 5000,
    parameter int unsigned SETUP_CYCLES      = 2,
    parameter int unsigned ENABLE_CYCLES     = 12,
    parameter int unsigned GAP_CYCLES        = 50,
    parameter int unsigned CMD_WAIT_CYCLES   = 2000,
    parameter int unsigned CLEAR_WAIT_CYCLES = 82000
) (
    input logic                  clk,
    input logic                  rst_n,
    lcd_write_sequencer_if.slave bus
);

    localparam logic [CntWidth-1:0] PwrLen    = CntWidth'(PWR_WAIT_CYCLES);
    localparam logic [CntWidth-1:0] Init1Len  = CntWidth'(INIT1_WAIT_CYCLES);
    localparam logic [CntWidth-1:0] Init2Len  = CntWidth'(INIT2_WAIT_CYCLES);
    localparam logic [CntWidth-1:0] SetupLen  = CntWidth'(SETUP_CYCLES);
    localparam logic [CntWidth-1:0] EnableLen = CntWidth'(ENABLE_CYCLES);
    localparam logic [CntWidth-1:0] StrobeLen = CntWidth'(SETUP_CYCLES + ENABLE_CYCLES);
    localparam logic [CntWidth-1:0] GapLen    = CntWidth'(GAP_CYCLES);
    localparam logic [CntWidth-1:0] CmdLen    = CntWidth'(CMD_WAIT_CYCLES);
    localparam logic [CntWidth-1:0] ClearLen  = CntWidth'(CLEAR_WAIT_CYCLES);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [1:0]          init_idx_q, init_idx_d;
    logic                init_done_q, init_done_d;
    logic                rs_q, rs_d;
    logic [7:0]          data_q, data_d;

    logic       cnt_done;
    logic       ready;
    phase_e     phase;
    logic       nib_rs;
    logic [3:0] nib;

    // Counter holds the remaining cycles including the current one.
    assign cnt_done = (cnt_q <= CntWidth'(1));
    assign ready    = (state_q == StIdle) && init_done_q;

    function automatic logic [CntWidth-1:0] init_wait_len(input logic [1:0] idx);
        case (idx)
            2'd0:    return Init1Len;
            2'd1:    return Init2Len;
            default: return CmdLen;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - CntWidth'(1) : cnt_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        rs_d        = rs_q;
        data_d      = data_q;
        case (state_q)
            StPwrWait: if (cnt_done) begin
                state_d = StInitNib;
                cnt_d   = StrobeLen;
            end
            StInitNib: if (cnt_done) begin
                state_d = StInitWait;
                cnt_d   = init_wait_len(init_idx_q);
            end
            StInitWait: if (cnt_done) begin
                if (init_idx_q == 2'd3) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end else begin
                    state_d    = StInitNib;
                    init_idx_d = init_idx_q + 2'd1;
                    cnt_d      = StrobeLen;
                end
            end
            StIdle: if (ready && bus.request) begin
                state_d = StSetupHi;
                rs_d    = bus.rs;
                data_d  = bus.data;
                cnt_d   = SetupLen;
            end
            StSetupHi: if (cnt_done) begin
                state_d = StEnHi;
                cnt_d   = EnableLen;
            end
            StEnHi: if (cnt_done) begin
                state_d = StGap;
                cnt_d   = GapLen;
            end
            StGap: if (cnt_done) begin
                state_d = StSetupLo;
                cnt_d   = SetupLen;
            end
            StSetupLo: if (cnt_done) begin
                state_d = StEnLo;
                cnt_d   = EnableLen;
            end
            StEnLo: if (cnt_done) begin
                state_d = StPostWait;
                cnt_d   = is_slow_cmd(rs_q, data_q) ? ClearLen : CmdLen;
            end
            StPostWait: if (cnt_done) state_d = StIdle;
            default: begin
                state_d = StPwrWait;
                cnt_d   = PwrLen;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPwrWait;
            cnt_q       <= PwrLen;
            init_idx_q  <= 2'd0;
            init_done_q <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
        end
    end

    // Hold phases keep RS/DB stable after E falls.
    always_comb begin
        phase  = PhOff;
        nib_rs = rs_q;
        nib    = data_q[7:4];
        case (state_q)
            StInitNib: begin
                phase  = PhStrobe;
                nib_rs = 1'b0;
                nib    = init_nibble(init_idx_q);
            end
            StInitWait: begin
                phase  = PhHold;
                nib_rs = 1'b0;
                nib    = init_nibble(init_idx_q);
            end
            StSetupHi:  phase = PhSetup;
            StEnHi:     phase = PhEnable;
            StGap:      phase = PhHold;
            StSetupLo: begin
                phase = PhSetup;
                nib   = data_q[3:0];
            end
            StEnLo: begin
                phase = PhEnable;
                nib   = data_q[3:0];
            end
            StPostWait: begin
                phase = PhHold;
                nib   = data_q[3:0];
            end
            default:    phase = PhOff;
        endcase
    end

    lcd_nibble_strobe #(
        .ENABLE_CYCLES(ENABLE_CYCLES)
    ) u_strobe (
        .phase (phase),
        .cnt   (cnt_q),
        .rs    (nib_rs),
        .nibble(nib),
        .e     (bus.lcd_e),
        .rs_out(bus.lcd_rs),
        .data  (bus.lcd_data)
    );

    assign bus.ready     = ready;
    assign bus.init_done = init_done_q;
    assign bus.lcd_sf_ce = 1'b1;
    assign bus.lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer with shortened timing parameters.
module tb_lcd_write_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    lcd_write_sequencer_if bus();

    lcd_write_sequencer #(
        .PWR_WAIT_CYCLES  (20),
        .INIT1_WAIT_CYCLES(10),
        .INIT2_WAIT_CYCLES(6),
        .SETUP_CYCLES     (2),
        .ENABLE_CYCLES    (3),
        .GAP_CYCLES       (4),
        .CMD_WAIT_CYCLES  (5),
        .CLEAR_WAIT_CYCLES(15)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: records each E-high window and counts RS/DB changes
    // while E is high or in the cycle right after it falls.
    logic [3:0] str_data [64];
    logic       str_rs   [64];
    int         str_cyc  [64];
    int         str_w    [64];
    int         n_str = 0;
    int         unstable = 0;
    logic       e_prev = 1'b0;
    logic [3:0] cap_d = 4'h0;
    logic       cap_rs = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            e_prev <= 1'b0;
        end else begin
            e_prev <= bus.lcd_e;
            if (bus.lcd_e && !e_prev) begin
                if (n_str < 63) begin
                    str_data[n_str] <= bus.lcd_data;
                    str_rs[n_str]   <= bus.lcd_rs;
                    str_cyc[n_str]  <= cyc;
                    str_w[n_str]    <= 1;
                    n_str           <= n_str + 1;
                end
                cap_d  <= bus.lcd_data;
                cap_rs <= bus.lcd_rs;
            end else if (bus.lcd_e) begin
                if (n_str > 0) str_w[n_str-1] <= str_w[n_str-1] + 1;
                if (bus.lcd_data !== cap_d || bus.lcd_rs !== cap_rs) unstable <= unstable + 1;
            end else if (e_prev) begin
                if (bus.lcd_data !== cap_d || bus.lcd_rs !== cap_rs) unstable <= unstable + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_init(output int cycles, output int ready_seen);
        cycles = 0;
        ready_seen = 0;
        while (bus.init_done !== 1'b1 && cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.ready === 1'b1 && bus.init_done !== 1'b1) ready_seen++;
        end
    endtask

    // Called at posedge+1 with ready high; returns cycles until ready again.
    task automatic send_byte(input logic rs, input logic [7:0] d, output int lat);
        bus.request = 1'b1;
        bus.rs = rs;
        bus.data = d;
        @(posedge clk);
        #1;
        bus.request = 1'b0;
        bus.rs = ~rs;
        bus.data = ~d;
        lat = 1;
        while (bus.ready !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic chk_init_strobes(input int b, input string tag);
        chk({tag, " strobe count"}, 32'(n_str - b), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, " nibble"}, 32'(str_data[b+i]), (i == 3) ? 32'h2 : 32'h3);
            chk({tag, " rs"}, 32'(str_rs[b+i]), 32'd0);
            chk({tag, " e width"}, 32'(str_w[b+i]), 32'd3);
        end
    endtask

    initial begin
        int         ncyc;
        int         rseen;
        int         lat;
        int         b;
        int         k;
        int         step;
        int         ecnt;
        logic       eprev;
        logic [7:0] expb [3];
        logic [8:0] vec [5];
        int         vlat [5];

        vec  = '{9'h001, 9'h101, 9'h003, 9'h004, 9'h002};
        vlat = '{30, 20, 30, 20, 30};

        bus.request = 1'b0;
        bus.rs = 1'b0;
        bus.data = 8'h00;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst ready", 32'(bus.ready), 32'd0);
        chk("rst init_done", 32'(bus.init_done), 32'd0);
        chk("rst lcd_e", 32'(bus.lcd_e), 32'd0);
        chk("rst lcd_rs", 32'(bus.lcd_rs), 32'd0);
        chk("rst lcd_data", 32'(bus.lcd_data), 32'd0);
        chk("rst sf_ce", 32'(bus.lcd_sf_ce), 32'd1);
        chk("rst rw", 32'(bus.lcd_rw), 32'd0);
        repeat (3) @(posedge clk);

        // Init sequence, with a request held during init that must be ignored
        bus.request = 1'b1;
        bus.rs = 1'b1;
        bus.data = 8'hAA;
        @(negedge clk);
        rst_n = 1'b1;
        b = n_str;
        wait_init(ncyc, rseen);
        bus.request = 1'b0;
        chk("init cycles", 32'(ncyc), 32'd66);
        chk("ready during init", 32'(rseen), 32'd0);
        chk("ready after init", 32'(bus.ready), 32'd1);
        chk_init_strobes(b, "init");

        // Data write 0x41
        b = n_str;
        send_byte(1'b1, 8'h41, lat);
        chk("0x41 latency", 32'(lat), 32'd20);
        chk("0x41 strobes", 32'(n_str - b), 32'd2);
        chk("0x41 hi", 32'(str_data[b]), 32'h4);
        chk("0x41 lo", 32'(str_data[b+1]), 32'h1);
        chk("0x41 rs hi", 32'(str_rs[b]), 32'd1);
        chk("0x41 rs lo", 32'(str_rs[b+1]), 32'd1);
        chk("0x41 e width", 32'(str_w[b+1]), 32'd3);
        chk("0x41 nibble spacing", 32'(str_cyc[b+1] - str_cyc[b]), 32'd9);
        chk("idle lcd_data", 32'(bus.lcd_data), 32'd0);
        chk("idle lcd_rs", 32'(bus.lcd_rs), 32'd0);
        chk("idle lcd_e", 32'(bus.lcd_e), 32'd0);

        // Post-byte wait: clear/home commands vs everything else
        for (int i = 0; i < 5; i++) begin
            b = n_str;
            send_byte(vec[i][8], vec[i][7:0], lat);
            chk("post wait latency", 32'(lat), 32'(vlat[i]));
            chk("post wait lo nibble", 32'(str_data[b+1]), 32'(vec[i][3:0]));
        end

        // Request held high with data changing every cycle
        b = n_str;
        k = 0;
        step = 0;
        bus.request = 1'b1;
        bus.rs = 1'b1;
        while (k < 3 && step < 200) begin
            bus.data = 8'(step * 29 + 7);
            if (bus.ready === 1'b1) begin
                expb[k] = bus.data;
                k++;
            end
            @(posedge clk);
            #1;
            step++;
        end
        bus.request = 1'b0;
        lat = 0;
        while (bus.ready !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("held accepts", 32'(k), 32'd3);
        chk("held strobes", 32'(n_str - b), 32'd6);
        for (int i = 0; i < 3; i++) begin
            chk("held hi", 32'(str_data[b+2*i]), 32'(expb[i][7:4]));
            chk("held lo", 32'(str_data[b+2*i+1]), 32'(expb[i][3:0]));
        end
        chk("back-to-back 1", 32'(str_cyc[b+2] - str_cyc[b]), 32'd20);
        chk("back-to-back 2", 32'(str_cyc[b+4] - str_cyc[b+2]), 32'd20);

        // Reset pulsed during the low-nibble enable
        bus.request = 1'b1;
        bus.rs = 1'b0;
        bus.data = 8'h28;
        ecnt = 0;
        eprev = 1'b0;
        for (int i = 0; i < 50 && ecnt < 2; i++) begin
            @(posedge clk);
            #1;
            bus.request = 1'b0;
            if (bus.lcd_e === 1'b1 && !eprev) ecnt++;
            eprev = bus.lcd_e;
        end
        chk("reached en_lo", 32'(ecnt), 32'd2);
        chk("e high before reset", 32'(bus.lcd_e), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst lcd_e", 32'(bus.lcd_e), 32'd0);
        chk("async rst data", 32'(bus.lcd_data), 32'd0);
        chk("async rst ready", 32'(bus.ready), 32'd0);
        chk("async rst init_done", 32'(bus.init_done), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        b = n_str;
        wait_init(ncyc, rseen);
        chk("reinit cycles", 32'(ncyc), 32'd66);
        chk_init_strobes(b, "reinit");
        repeat (10) @(posedge clk);
        #1;
        chk("no stale byte", 32'(n_str - b), 32'd4);
        chk("ready after reinit", 32'(bus.ready), 32'd1);
        chk("rs/data stability", 32'(unstable), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
